layer_output_serializer: RTL and testbench
==========================================

Name: layer_output_serializer

Overview:
Transmit side of the per-layer input-index protocol. Captures a layer's full parallel output vector in one cycle, then streams it one element per beat with an element index, valid/ready handshake and last flag. The downstream layer's input counter consumes the stream. Sits between one layer's neuron array and the next layer's input sequencer.

Parameters:
numOutputs, 16, number of elements per vector (≥2)
dataWidth, 16, bits per element
idxWidth, $clog2(numOutputs+1), width of the index output

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
load  in  1  capture request for dataIn; one-cycle pulse
dataIn  in  numOutputs*dataWidth  flat vector; element k at bits [k*dataWidth +: dataWidth]
clear  in  1  synchronous abort; returns to IDLE
outReady  in  1  downstream accepts current beat
outData  out  dataWidth  current element
outIndex  out  idxWidth  index of current element, 0..numOutputs-1
outValid  out  1  beat valid
outLast  out  1  high with outValid when outIndex == numOutputs-1
busy  out  1  high in SEND
done  out  1  one-cycle pulse after last beat accepted
overrun  out  1  sticky; load seen while busy

Behaviour:
- Reset (reset=0, async): state=IDLE; outData=0, outIndex=0, outValid=0, outLast=0, busy=0, done=0, overrun=0; capture register cleared.
- States: IDLE, SEND. No other states; encoding from package.
- IDLE: on load=1, register all of dataIn, index←0, go to SEND. Load-to-first-beat latency is 1 cycle: outValid=1 with outIndex=0 in the cycle after load.
- SEND: outValid=1; outData=captured[outIndex]; outLast=(outIndex==numOutputs-1).
- Handshake: a beat transfers when outValid && outReady. Without a transfer, outData, outIndex and outLast stay stable and outValid stays high. outReady may be held high continuously, which gives 1 beat/cycle.
- On a transfer with outLast=0: index+1.
- On a transfer with outLast=1: index←0 (wrap), state←IDLE, outValid←0, done=1 for exactly the next cycle.
- done is registered. It is 0 at all other times.
- load in SEND: ignored (capture register unchanged); overrun←1 and stays 1 until reset.
- load in the same cycle as the final transfer: treated as arriving in SEND, so it is ignored and sets overrun. A new vector can only load from IDLE.
- clear=1 (any state): state←IDLE, index←0, outValid←0, done not pulsed. clear has priority over load and transfer in the same cycle. overrun is not affected.
- outReady while outValid=0: no effect.
- Reset mid-stream: immediate return to reset values; a partially sent vector is discarded.
- Index arithmetic: unsigned idxWidth; never exceeds numOutputs-1. Non-power-of-2 numOutputs is supported (e.g. 10).

Decomposition:
- Package nn_stream_pkg: state typedef enum {IDLE, SEND}; helper function elem_sel(vector, k) for the flat-vector slice.
- Sub-module serializer_index_counter contains:
  - the modulo-numOutputs index register with enable (transfer), clear and last flag;
  - the mirror of the downstream input counter.
- Top level holds the FSM, capture register, output mux and the done/overrun flags.

Test Plan:
- numOutputs=4, dataWidth=8, dataIn={8'h44,8'h33,8'h22,8'h11}, load 1 cycle, outReady=1 → beats 11,22,33,44 on cycles 1-4 with idx 0-3; outLast on idx 3; done pulse on cycle 5; busy low on cycle 5.
- Same load, outReady toggled 1,0,0,1,1,0,1 → each element held stable while not ready; all 4 delivered in order, no duplicate or skipped index.
- load again at idx 2 with different data → stream continues with the original data; overrun=1 and stays 1 after done.
- clear asserted at idx 1 with outReady=1 → next cycle outValid=0, outIndex=0, no done; a new load then streams from idx 0.
- reset=0 pulsed asynchronously mid-beat at idx 2 → all outputs 0 immediately, without waiting for a clock edge.
- numOutputs=10 → idx runs 0..9, outLast only at 9, wraps to 0, 10 beats per load.

Source files
------------

// File: rtl/nn_stream_pkg.sv
// rtl/nn_stream_pkg.sv - shared state encoding and flat-vector slice helper
package nn_stream_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Widest flat vector the slice helper handles; callers size-cast in and out.
   localparam int VEC_MAX = 4096;

   // Element k of a flat vector whose elements are w bits wide, in the low bits.
   function automatic logic [VEC_MAX-1:0] elem_sel(input logic [VEC_MAX-1:0] vector,
                                                   input int k, input int w);
      return vector >> (k * w);
   endfunction

endpackage

// File: rtl/layer_output_serializer_if.sv
// rtl/layer_output_serializer_if.sv - element stream from a layer to the next layer
interface layer_output_serializer_if #(
   parameter int dataWidth = 16,
   parameter int idxWidth  = 5
);
   logic [dataWidth-1:0] outData;
   logic [idxWidth-1:0]  outIndex;
   logic                 outValid;
   logic                 outLast;
   logic                 outReady;

   modport master (output outData, output outIndex, output outValid, output outLast,
                   input outReady);
   modport slave  (input outData, input outIndex, input outValid, input outLast,
                   output outReady);
endinterface

// File: rtl/serializer_index_counter.sv
// rtl/serializer_index_counter.sv - modulo element index plus mirror of the receiver's counter
module serializer_index_counter #(
   parameter int numOutputs = 16,
   parameter int idxWidth   = $clog2(numOutputs + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                enable,
   output logic [idxWidth-1:0] index,
   output logic                last,
   output logic                vector_done
);
   localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(numOutputs - 1);

   // Tracks how many beats the downstream input counter has taken this vector;
   // its wrap marks the end of the vector independently of the transmit index.
   logic [idxWidth-1:0] mirror;

   assign last        = (index == LAST_IDX);
   assign vector_done = enable && (mirror == LAST_IDX);

   // Transmit index: restart on clear, wrap to 0 after the last element.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         index <= '0;
      else if (clear)
         index <= '0;
      else if (enable)
         index <= last ? '0 : index + idxWidth'(1);
   end

   // Receiver mirror: counts accepted beats, wrapping the same way the receiver does.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         mirror <= '0;
      else if (clear)
         mirror <= '0;
      else if (enable)
         mirror <= (mirror == LAST_IDX) ? '0 : mirror + idxWidth'(1);
   end

endmodule

// File: rtl/layer_output_serializer.sv
// rtl/layer_output_serializer.sv - captures a layer output vector and streams it element by element
module layer_output_serializer
   import nn_stream_pkg::*;
#(
   parameter int numOutputs = 16,
   parameter int dataWidth  = 16,
   parameter int idxWidth   = $clog2(numOutputs + 1)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            load,
   input  logic [numOutputs*dataWidth-1:0] dataIn,
   input  logic                            clear,
   layer_output_serializer_if.master       out_if,
   output logic                            busy,
   output logic                            done,
   output logic                            overrun
);
   state_t                          state, state_next;
   logic [numOutputs*dataWidth-1:0] captured;
   logic [idxWidth-1:0]             index;
   logic                            last;
   logic                            vector_done;
   logic                            start;
   logic                            transfer;

   // A load only captures from IDLE; a load while streaming is flagged as overrun.
   assign start    = (state == IDLE) && load && !clear;
   assign transfer = (state == SEND) && out_if.outReady && !clear;

   serializer_index_counter #(
      .numOutputs(numOutputs),
      .idxWidth  (idxWidth)
   ) u_index (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear || start),
      .enable     (transfer),
      .index      (index),
      .last       (last),
      .vector_done(vector_done)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next state: clear wins, then load from IDLE, then the final accepted beat.
   always_comb begin
      state_next = state;
      if (clear)
         state_next = IDLE;
      else begin
         case (state)
            IDLE: if (load)        state_next = SEND;
            SEND: if (vector_done) state_next = IDLE;
            default:               state_next = IDLE;
         endcase
      end
   end

   // Stream outputs follow the state; data is the captured element at the current index.
   always_comb begin
      out_if.outValid = 1'b0;
      out_if.outLast  = 1'b0;
      out_if.outData  = '0;
      busy            = 1'b0;
      if (state == SEND) begin
         out_if.outValid = 1'b1;
         out_if.outLast  = last;
         out_if.outData  = dataWidth'(elem_sel(VEC_MAX'(captured), int'(index), dataWidth));
         busy            = 1'b1;
      end
   end

   assign out_if.outIndex = index;

   // Capture register: loaded only when a new vector starts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         captured <= '0;
      else if (start)
         captured <= dataIn;
   end

   // done pulses the cycle after the final beat; overrun latches until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         done    <= transfer && vector_done;
         overrun <= overrun || (load && (state == SEND));
      end
   end

endmodule

// File: tb/tb_layer_output_serializer.sv
// tb/tb_layer_output_serializer.sv - directed self-checking bench for layer_output_serializer
module tb_layer_output_serializer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load4 = 1'b0, clear4 = 1'b0;
   logic [31:0] din4 = '0;
   logic        busy4, done4, overrun4;
   logic        load10 = 1'b0, clear10 = 1'b0;
   logic [79:0] din10 = '0;
   logic        busy10, done10, overrun10;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   layer_output_serializer_if #(.dataWidth(8), .idxWidth(3)) if4 ();
   layer_output_serializer_if #(.dataWidth(8), .idxWidth(4)) if10 ();

   layer_output_serializer #(.numOutputs(4), .dataWidth(8)) dut4 (
      .clk(clk), .reset(reset), .load(load4), .dataIn(din4), .clear(clear4),
      .out_if(if4), .busy(busy4), .done(done4), .overrun(overrun4)
   );

   layer_output_serializer #(.numOutputs(10), .dataWidth(8)) dut10 (
      .clk(clk), .reset(reset), .load(load10), .dataIn(din10), .clear(clear10),
      .out_if(if10), .busy(busy10), .done(done10), .overrun(overrun10)
   );

   task automatic test_reset();
      reset = 1'b0;
      if4.outReady = 1'b0;
      if10.outReady = 1'b0;
      #12;
      checks++;
      if ({if4.outValid, if4.outLast, if4.outData, if4.outIndex, busy4, done4, overrun4} !== 16'h0) begin
         failures++;
         $display("FAIL reset4: got valid=%b last=%b data=%h idx=%0d busy=%b done=%b ovr=%b, want all 0",
                  if4.outValid, if4.outLast, if4.outData, if4.outIndex, busy4, done4, overrun4);
      end
      checks++;
      if ({if10.outValid, if10.outLast, if10.outData, if10.outIndex, busy10, done10, overrun10} !== 17'h0) begin
         failures++;
         $display("FAIL reset10: got valid=%b data=%h idx=%0d, want all 0",
                  if10.outValid, if10.outData, if10.outIndex);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Start a 4-element vector: load pulse issued at a negedge.
   task automatic start4(input logic [31:0] d, input logic rdy);
      @(negedge clk);
      din4 = d;
      load4 = 1'b1;
      if4.outReady = rdy;
      @(negedge clk);
      load4 = 1'b0;
   endtask

   task automatic test_stream();
      logic [7:0] exp;
      start4({8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
      for (int i = 0; i < 4; i++) begin
         exp = 8'(8'h11 * (i + 1));
         checks++;
         if (if4.outValid !== 1'b1 || if4.outIndex !== 3'(i) || if4.outData !== exp ||
             if4.outLast !== (i == 3) || busy4 !== 1'b1 || done4 !== 1'b0) begin
            failures++;
            $display("FAIL stream beat %0d: got valid=%b idx=%0d data=%h last=%b busy=%b done=%b, want 1 %0d %h %b 1 0",
                     i, if4.outValid, if4.outIndex, if4.outData, if4.outLast, busy4, done4, i, exp, (i == 3));
         end
         @(negedge clk);
      end
      checks++;
      if (if4.outValid !== 1'b0 || done4 !== 1'b1 || busy4 !== 1'b0 || if4.outIndex !== 3'd0) begin
         failures++;
         $display("FAIL stream_done: got valid=%b done=%b busy=%b idx=%0d, want 0 1 0 0",
                  if4.outValid, done4, busy4, if4.outIndex);
      end
      @(negedge clk);
      checks++;
      if (done4 !== 1'b0 || overrun4 !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse_width: got done=%b ovr=%b, want 0 0", done4, overrun4);
      end
   endtask

   task automatic test_backpressure();
      logic [6:0] pattern = 7'b1011001;   // bit c = outReady in cycle c: 1,0,0,1,1,0,1
      int         exp_idx = 0;
      logic [7:0] exp;
      start4({8'h44, 8'h33, 8'h22, 8'h11}, 1'b0);
      for (int c = 0; c < 7; c++) begin
         exp = 8'(8'h11 * (exp_idx + 1));
         checks++;
         if (if4.outValid !== 1'b1 || if4.outIndex !== 3'(exp_idx) || if4.outData !== exp ||
             if4.outLast !== (exp_idx == 3)) begin
            failures++;
            $display("FAIL backpressure cycle %0d: got valid=%b idx=%0d data=%h last=%b, want 1 %0d %h %b",
                     c, if4.outValid, if4.outIndex, if4.outData, if4.outLast, exp_idx, exp, (exp_idx == 3));
         end
         if4.outReady = pattern[c];
         if (pattern[c]) exp_idx++;
         @(negedge clk);
      end
      if4.outReady = 1'b0;
      checks++;
      if (done4 !== 1'b1 || if4.outValid !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_done: got done=%b valid=%b, want 1 0", done4, if4.outValid);
      end
      @(negedge clk);
   endtask

   task automatic test_overrun();
      logic [7:0] exp;
      checks++;
      if (overrun4 !== 1'b0) begin
         failures++;
         $display("FAIL overrun_initial: got %b, want 0", overrun4);
      end
      start4({8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
      for (int i = 0; i < 4; i++) begin
         exp = 8'(8'h11 * (i + 1));
         checks++;
         if (if4.outIndex !== 3'(i) || if4.outData !== exp || if4.outValid !== 1'b1) begin
            failures++;
            $display("FAIL overrun beat %0d: got idx=%0d data=%h valid=%b, want %0d %h 1",
                     i, if4.outIndex, if4.outData, if4.outValid, i, exp);
         end
         if (i == 2) begin
            din4 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
            load4 = 1'b1;
         end else
            load4 = 1'b0;
         @(negedge clk);
      end
      load4 = 1'b0;
      checks++;
      if (done4 !== 1'b1 || overrun4 !== 1'b1) begin
         failures++;
         $display("FAIL overrun_after_done: got done=%b ovr=%b, want 1 1", done4, overrun4);
      end
      @(negedge clk);
      checks++;
      if (overrun4 !== 1'b1 || busy4 !== 1'b0) begin
         failures++;
         $display("FAIL overrun_sticky: got ovr=%b busy=%b, want 1 0", overrun4, busy4);
      end
   endtask

   task automatic test_clear();
      start4({8'h88, 8'h77, 8'h66, 8'h55}, 1'b1);
      @(negedge clk);
      checks++;
      if (if4.outIndex !== 3'd1 || if4.outData !== 8'h66) begin
         failures++;
         $display("FAIL clear_pre: got idx=%0d data=%h, want 1 66", if4.outIndex, if4.outData);
      end
      clear4 = 1'b1;
      @(negedge clk);
      clear4 = 1'b0;
      checks++;
      if (if4.outValid !== 1'b0 || if4.outIndex !== 3'd0 || done4 !== 1'b0 || busy4 !== 1'b0) begin
         failures++;
         $display("FAIL clear_abort: got valid=%b idx=%0d done=%b busy=%b, want 0 0 0 0",
                  if4.outValid, if4.outIndex, done4, busy4);
      end
      @(negedge clk);
      checks++;
      if (done4 !== 1'b0 || overrun4 !== 1'b1) begin
         failures++;
         $display("FAIL clear_no_done: got done=%b ovr=%b, want 0 1", done4, overrun4);
      end
      start4({8'h88, 8'h77, 8'h66, 8'h55}, 1'b1);
      checks++;
      if (if4.outValid !== 1'b1 || if4.outIndex !== 3'd0 || if4.outData !== 8'h55) begin
         failures++;
         $display("FAIL clear_reload: got valid=%b idx=%0d data=%h, want 1 0 55",
                  if4.outValid, if4.outIndex, if4.outData);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (done4 !== 1'b1) begin
         failures++;
         $display("FAIL clear_reload_done: got done=%b, want 1", done4);
      end
   endtask

   task automatic test_async_reset();
      start4({8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (if4.outIndex !== 3'd2 || if4.outData !== 8'h33) begin
         failures++;
         $display("FAIL areset_pre: got idx=%0d data=%h, want 2 33", if4.outIndex, if4.outData);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({if4.outValid, if4.outLast, if4.outData, if4.outIndex, busy4, done4, overrun4} !== 16'h0) begin
         failures++;
         $display("FAIL areset_immediate: got valid=%b last=%b data=%h idx=%0d busy=%b done=%b ovr=%b, want all 0",
                  if4.outValid, if4.outLast, if4.outData, if4.outIndex, busy4, done4, overrun4);
      end
      @(negedge clk);
      reset = 1'b1;
      if4.outReady = 1'b0;
      @(negedge clk);
      checks++;
      if (if4.outValid !== 1'b0 || if4.outData !== 8'h00) begin
         failures++;
         $display("FAIL areset_discard: got valid=%b data=%h, want 0 00", if4.outValid, if4.outData);
      end
   endtask

   task automatic test_ten();
      logic [7:0] exp;
      @(negedge clk);
      for (int k = 0; k < 10; k++) din10[k*8 +: 8] = 8'(8'hA0 + k);
      load10 = 1'b1;
      if10.outReady = 1'b1;
      @(negedge clk);
      load10 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         exp = 8'(8'hA0 + i);
         checks++;
         if (if10.outValid !== 1'b1 || if10.outIndex !== 4'(i) || if10.outData !== exp ||
             if10.outLast !== (i == 9)) begin
            failures++;
            $display("FAIL ten beat %0d: got valid=%b idx=%0d data=%h last=%b, want 1 %0d %h %b",
                     i, if10.outValid, if10.outIndex, if10.outData, if10.outLast, i, exp, (i == 9));
         end
         @(negedge clk);
      end
      checks++;
      if (done10 !== 1'b1 || if10.outValid !== 1'b0 || if10.outIndex !== 4'd0 || overrun10 !== 1'b0) begin
         failures++;
         $display("FAIL ten_done: got done=%b valid=%b idx=%0d ovr=%b, want 1 0 0 0",
                  done10, if10.outValid, if10.outIndex, overrun10);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_overrun();
      test_clear();
      test_async_reset();
      test_ten();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
